// File: rtl/msg_req_scheduler.sv
// Arbitrates session-level admin requests (buffered FIFO) and an app ready/valid
// source into a single create-message engine, one outstanding message at a time.
`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 4
`endif
`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 32
`endif
`ifndef VALUE_SIZE
`define VALUE_SIZE 8
`endif
`ifndef LOGON
`define LOGON 4'd1
`endif
`ifndef LOGOUT
`define LOGOUT 4'd2
`endif
`ifndef HEARTBEAT
`define HEARTBEAT 4'd3
`endif
`ifndef resendReq
`define resendReq 4'd4
`endif

module msg_req_scheduler #(
   parameter int NUM_HOST     = `HOST_ADDR_WIDTH,
   parameter int VALUE_WIDTH  = `VALUE_DATA_WIDTH,
   parameter int SIZE         = `VALUE_SIZE,
   parameter int DEPTH        = 8,
   parameter int MAX_BURST    = 4,
   parameter int DONE_TIMEOUT = 1023
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       admin_req_i,
   input  logic [3:0]                 admin_type_i,
   input  logic [NUM_HOST-1:0]        admin_host_i,
   input  logic [VALUE_WIDTH-1:0]     admin_tcid_i,
   input  logic [SIZE-1:0]            admin_sv_i,
   input  logic                       app_valid_i,
   output logic                       app_ready_o,
   input  logic [3:0]                 app_type_i,
   input  logic [NUM_HOST-1:0]        app_host_i,
   input  logic [VALUE_WIDTH-1:0]     app_tcid_i,
   input  logic [SIZE-1:0]            app_sv_i,
   input  logic                       cm_busy_i,
   input  logic                       cm_done_i,
   output logic [3:0]                 create_message_o,
   output logic                       initiate_msg_o,
   output logic [NUM_HOST-1:0]        host_o,
   output logic [VALUE_WIDTH-1:0]     targetCompId_o,
   output logic [SIZE-1:0]            s_v_targetCompId_o,
   output logic                       overflow_o,
   output logic                       timeout_o,
   output logic [$clog2(DEPTH):0]     fifo_count_o
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int EW  = 4 + NUM_HOST + VALUE_WIDTH + SIZE;
   localparam int WDW = $clog2(DONE_TIMEOUT + 1);
   localparam int BW  = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, WAIT_DONE} state_t;

   state_t               state, state_n;
   logic [EW-1:0]        mem [DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;
   logic [WDW-1:0]       wd_cnt, wd_n;
   logic [BW-1:0]        burst_cnt, burst_n;
   logic                 fifo_empty, fifo_full;
   logic                 push, pop, issue, sel_app, timeout_n;
   logic [3:0]           h_type;
   logic [NUM_HOST-1:0]  h_host;
   logic [VALUE_WIDTH-1:0] h_tcid;
   logic [SIZE-1:0]      h_sv;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(DEPTH));
   assign {h_type, h_host, h_tcid, h_sv} = mem[rd_ptr];
   // A full FIFO still accepts a request when the head leaves in the same cycle.
   assign push = admin_req_i && (!fifo_full || pop);
   assign fifo_count_o = count;

   always_comb begin
      state_n     = state;
      wd_n        = wd_cnt;
      burst_n     = burst_cnt;
      pop         = 1'b0;
      issue       = 1'b0;
      sel_app     = 1'b0;
      app_ready_o = 1'b0;
      timeout_n   = 1'b0;
      case (state)
         IDLE: begin
            if (!cm_busy_i) begin
               if (!fifo_empty && (!app_valid_i || burst_cnt < BW'(MAX_BURST))) begin
                  pop   = 1'b1;
                  issue = 1'b1;
                  if (burst_cnt != BW'(MAX_BURST))
                     burst_n = burst_cnt + 1'b1;
               end else if (app_valid_i) begin
                  app_ready_o = 1'b1;
                  sel_app     = 1'b1;
                  issue       = 1'b1;
                  burst_n     = '0;
               end
            end
            if (issue) begin
               state_n = WAIT_DONE;
               wd_n    = '0;
            end
         end
         WAIT_DONE: begin
            if (cm_done_i) begin
               state_n = IDLE;
            end else if (wd_cnt == WDW'(DONE_TIMEOUT)) begin
               timeout_n = 1'b1;
               state_n   = IDLE;
            end else begin
               wd_n = wd_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (!app_valid_i)
         burst_n = '0;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {admin_type_i, admin_host_i, admin_tcid_i, admin_sv_i};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         count              <= '0;
         wd_cnt             <= '0;
         burst_cnt          <= '0;
         overflow_o         <= 1'b0;
         timeout_o          <= 1'b0;
         initiate_msg_o     <= 1'b0;
         create_message_o   <= '0;
         host_o             <= '0;
         targetCompId_o     <= '0;
         s_v_targetCompId_o <= '0;
      end else begin
         state          <= state_n;
         wd_cnt         <= wd_n;
         burst_cnt      <= burst_n;
         timeout_o      <= timeout_n;
         initiate_msg_o <= issue;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (admin_req_i && !push)
            overflow_o <= 1'b1;
         if (issue) begin
            create_message_o   <= sel_app ? app_type_i : h_type;
            host_o             <= sel_app ? app_host_i : h_host;
            targetCompId_o     <= sel_app ? app_tcid_i : h_tcid;
            s_v_targetCompId_o <= sel_app ? app_sv_i   : h_sv;
         end
      end
   end

endmodule
